// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - ALU/MEM writeback requests and registered regfile write port
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 5
) ();
  logic                     alu_valid;
  logic [ADDRESS_WIDTH-1:0] alu_wa;
  logic [DATA_WIDTH-1:0]    alu_wd;
  logic                     alu_ready;

  logic                     mem_valid;
  logic [ADDRESS_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic                     mem_ready;

  logic                     RegWrite;
  logic [ADDRESS_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0]    wd;
  logic                     init_done;

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    output alu_ready,
    input  mem_valid, mem_wa, mem_wd,
    output mem_ready,
    output RegWrite, wa, wd, init_done
  );

  modport master (
    output alu_valid, alu_wa, alu_wd,
    input  alu_ready,
    output mem_valid, mem_wa, mem_wd,
    input  mem_ready,
    input  RegWrite, wa, wd, init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - clears the regfile after reset, then arbitrates ALU/MEM writebacks
// REGFILE_WB_RR_ARB_EN selects round-robin arbitration; otherwise MEM has fixed priority.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 5,
  parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_init_cnt;
  logic [ADDRESS_WIDTH-1:0] w_init_cnt_next;
  logic                     r_init_done;
  logic                     w_init_done_next;
  logic                     w_init_last;

  logic                     w_contested;
  logic                     w_mem_wins;
  logic                     w_alu_grant;
  logic                     w_mem_grant;

  logic                     r_reg_write;
  logic [ADDRESS_WIDTH-1:0] r_wa;
  logic [DATA_WIDTH-1:0]    r_wd;
  logic                     w_reg_write_next;
  logic [ADDRESS_WIDTH-1:0] w_wa_next;
  logic [DATA_WIDTH-1:0]    w_wd_next;

  assign w_init_last = (r_init_cnt == ADDRESS_WIDTH'(REGISTER_SIZE - 1));
  assign w_contested = bus.alu_valid & bus.mem_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_cnt  <= w_init_cnt_next;
      r_init_done <= w_init_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_init_cnt_next  = r_init_cnt;
    w_init_done_next = r_init_done;
    case (r_state)
      S_INIT: begin
        w_init_cnt_next = r_init_cnt + ADDRESS_WIDTH'(1);
        if (w_init_last) begin
          w_state_next     = S_RUN;
          w_init_cnt_next  = '0;
          w_init_done_next = 1'b1;
        end
      end
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_INIT;
    endcase
  end

`ifdef REGFILE_WB_RR_ARB_EN
  // Pointer moves only on contested grants; 0 favours MEM.
  logic r_rr_favour_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_favour_alu <= 1'b0;
    end else if (r_state == S_RUN && w_contested) begin
      r_rr_favour_alu <= w_mem_grant;
    end
  end

  assign w_mem_wins = ~r_rr_favour_alu;
`else
  assign w_mem_wins = 1'b1;
`endif

  always_comb begin
    w_alu_grant      = 1'b0;
    w_mem_grant      = 1'b0;
    w_reg_write_next = 1'b0;
    w_wa_next        = r_wa;
    w_wd_next        = r_wd;
    if (r_state == S_RUN) begin
      if (w_contested) begin
        w_mem_grant = w_mem_wins;
        w_alu_grant = ~w_mem_wins;
      end else begin
        w_mem_grant = bus.mem_valid;
        w_alu_grant = bus.alu_valid;
      end
    end
    if (r_state == S_INIT) begin
      w_reg_write_next = 1'b1;
      w_wa_next        = r_init_cnt;
      w_wd_next        = '0;
    end else if (w_mem_grant) begin
      // x0 is hardwired zero: accept the request but suppress the write strobe
      w_reg_write_next = |bus.mem_wa;
      w_wa_next        = bus.mem_wa;
      w_wd_next        = bus.mem_wd;
    end else if (w_alu_grant) begin
      w_reg_write_next = |bus.alu_wa;
      w_wa_next        = bus.alu_wa;
      w_wd_next        = bus.alu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
    end else begin
      r_reg_write <= w_reg_write_next;
      r_wa        <= w_wa_next;
      r_wd        <= w_wd_next;
    end
  end

  assign bus.alu_ready = w_alu_grant;
  assign bus.mem_ready = w_mem_grant;
  assign bus.RegWrite  = r_reg_write;
  assign bus.wa        = r_wa;
  assign bus.wd        = r_wd;
  assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter (init clear, arbitration, reset abort)
module tb_regfile_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int RS = 2**AW;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t sb[$];

  bit            m_init;
  int            m_cnt;
  bit            m_done;
  bit            m_fav_alu;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  bit            m_alu_xfer;
  bit            m_mem_xfer;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  regfile_wb_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTER_SIZE(RS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Check the outputs of the current cycle, predict the next registered outputs, then take the edge.
  task automatic cycle();
    exp_t e;
    exp_t n;
    logic ar;
    logic mr;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk("RegWrite", bus.RegWrite, e.we);
      chk("wa", bus.wa, e.wa);
      chk("wd", bus.wd, e.wd);
      chk("init_done", bus.init_done, e.done);
    end
    ar = 1'b0;
    mr = 1'b0;
    if (!m_init) begin
      if (bus.alu_valid && bus.mem_valid) begin
`ifdef REGFILE_WB_RR_ARB_EN
        mr = !m_fav_alu;
        ar = m_fav_alu;
        m_fav_alu = mr;
`else
        mr = 1'b1;
`endif
      end else begin
        mr = bus.mem_valid;
        ar = bus.alu_valid;
      end
    end
    chk("alu_ready", bus.alu_ready, ar);
    chk("mem_ready", bus.mem_ready, mr);
    n.we = 1'b0;
    if (m_init) begin
      n.we = 1'b1;
      m_wa = m_cnt[AW-1:0];
      m_wd = '0;
      if (m_cnt == RS - 1) begin
        m_init = 1'b0;
        m_done = 1'b1;
      end
      m_cnt++;
    end else if (mr) begin
      n.we = (bus.mem_wa != 0);
      m_wa = bus.mem_wa;
      m_wd = bus.mem_wd;
    end else if (ar) begin
      n.we = (bus.alu_wa != 0);
      m_wa = bus.alu_wa;
      m_wd = bus.alu_wd;
    end
    n.wa = m_wa;
    n.wd = m_wd;
    n.done = m_done;
    sb.push_back(n);
    m_alu_xfer = ar;
    m_mem_xfer = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t z;
    reset = 1'b1;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("rst_RegWrite", bus.RegWrite, 1'b0);
    chk("rst_wa", bus.wa, '0);
    chk("rst_wd", bus.wd, '0);
    chk("rst_init_done", bus.init_done, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_RegWrite", bus.RegWrite, 1'b0);
    reset = 1'b0;
    sb.delete();
    m_init = 1'b1; m_cnt = 0; m_done = 1'b0; m_fav_alu = 1'b0;
    m_wa = '0; m_wd = '0; m_alu_xfer = 1'b0; m_mem_xfer = 1'b0;
    z.we = 1'b0; z.wa = '0; z.wd = '0; z.done = 1'b0;
    sb.push_back(z);
  endtask

  task automatic wait_alu_grant(input string tag, input int budget);
    int k;
    k = 0;
    while (!m_alu_xfer && k < budget) begin
      cycle();
      k++;
    end
    if (!m_alu_xfer) chk(tag, 1'b0, 1'b1);
    bus.alu_valid = 1'b0;
  endtask

  task automatic wait_mem_grant(input string tag, input int budget);
    int k;
    k = 0;
    while (!m_mem_xfer && k < budget) begin
      cycle();
      k++;
    end
    if (!m_mem_xfer) chk(tag, 1'b0, 1'b1);
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_wa = '0; bus.alu_wd = '0;
    bus.mem_valid = 1'b0; bus.mem_wa = '0; bus.mem_wd = '0;
    m_alu_xfer = 1'b0; m_mem_xfer = 1'b0;
    #2;

    // full clear sequence with no traffic
    do_reset();
    repeat (RS + 3) cycle();

    // single ALU write
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 64'hDEAD;
    m_alu_xfer = 1'b0;
    wait_alu_grant("alu_grant_timeout", 4);
    repeat (2) cycle();

    // x0 load: accepted but write suppressed
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd0; bus.mem_wd = 64'h1234;
    m_mem_xfer = 1'b0;
    wait_mem_grant("mem_grant_timeout", 4);
    repeat (2) cycle();

    // contested for four cycles, then drain
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd3; bus.alu_wd = 64'hA1A1;
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd4; bus.mem_wd = 64'hB2B2;
    repeat (4) cycle();
    bus.mem_valid = 1'b0;
    m_alu_xfer = 1'b0;
    wait_alu_grant("contest_drain_timeout", 4);
    repeat (2) cycle();

    // same target address from both sides
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd9; bus.alu_wd = 64'h1111;
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd9; bus.mem_wd = 64'h2222;
    m_mem_xfer = 1'b0;
    wait_mem_grant("same_wa_mem_timeout", 4);
    m_alu_xfer = m_alu_xfer;
    wait_alu_grant("same_wa_alu_timeout", 4);
    repeat (2) cycle();

    // random traffic obeying the hold-until-ready rule
    for (int i = 0; i < 300; i++) begin
      if (!bus.alu_valid || m_alu_xfer) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_wa = AW'($urandom);
        bus.alu_wd = {$urandom, $urandom};
      end
      if (!bus.mem_valid || m_mem_xfer) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_wa = AW'($urandom);
        bus.mem_wd = {$urandom, $urandom};
      end
      cycle();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (2) cycle();

    // reset mid-way through INIT restarts the clear sequence
    do_reset();
    repeat (10) cycle();
    #2;
    do_reset();
    repeat (RS + 2) cycle();

    // request raised during INIT waits for the first RUN cycle
    do_reset();
    repeat (5) cycle();
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd7; bus.alu_wd = 64'hCAFE_F00D;
    m_alu_xfer = 1'b0;
    wait_alu_grant("init_alu_timeout", RS + 4);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter REGISTER_SIZE, default 2**ADDRESS_WIDTH, number of registers cleared at init.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports alu_valid (input, 1), alu_wa (input, ADDRESS_WIDTH) and alu_wd (input, DATA_WIDTH), ALU writeback request.
REQ-007 SHALL have port alu_ready, output, 1, ALU request accepted this cycle.
REQ-008 SHALL have ports mem_valid (input, 1), mem_wa (input, ADDRESS_WIDTH) and mem_wd (input, DATA_WIDTH), load writeback request.
REQ-009 SHALL have port mem_ready, output, 1, MEM request accepted this cycle.
REQ-010 SHALL have ports RegWrite (output, 1), wa (output, ADDRESS_WIDTH) and wd (output, DATA_WIDTH), registered regfile write port.
REQ-011 SHALL have port init_done, output, 1, regfile clear sequence complete.

Function
REQ-012 SHALL implement a two-state FSM: INIT (entered on reset) and RUN.
REQ-013 In INIT, SHALL drive RegWrite=1, wd=0 and wa=0,1,...,REGISTER_SIZE-1 on successive rising edges after reset release, one address per cycle.
REQ-014 After the edge issuing wa=REGISTER_SIZE-1, SHALL enter RUN and set init_done=1 on that same edge; init_done SHALL then stay 1 until reset.
REQ-015 SHALL hold alu_ready=0 and mem_ready=0 throughout INIT, regardless of valid inputs.
REQ-016 In RUN, ready outputs SHALL be combinational: a requester is granted when its valid=1 and it wins arbitration; at most one ready SHALL be 1 per cycle.
REQ-017 Transfer occurs when valid && ready; requesters SHALL hold valid, wa and wd stable until ready.
REQ-018 On the edge following a transfer, SHALL present RegWrite=1 with wa/wd of the granted requester (one-cycle latency).
REQ-019 A transfer with wa=0 SHALL be accepted (ready=1) but SHALL produce RegWrite=0 on the following cycle (x0 write suppressed).
REQ-020 On cycles with no transfer, SHALL drive RegWrite=0 and hold wa/wd at their previous values.
REQ-021 With only one valid, SHALL grant it in the same cycle.
REQ-022 Both requesters valid with equal wa SHALL be treated as an ordinary conflict; the loser SHALL write on a later cycle, so the later-granted data is final.
REQ-023 Outputs SHALL change only on rising clk edges, so the regfile samples stable values at the following falling edge.

Reset
REQ-024 On reset assertion, SHALL immediately force RegWrite=0, wa=0, wd=0, init_done=0, state=INIT, init counter=0 and the round-robin pointer to favour MEM.
REQ-025 Reset asserted during INIT or RUN SHALL abort the current activity; any pending request SHALL be dropped and the full clear sequence SHALL restart after release.

Configuration
REQ-026 With macro REGFILE_WB_RR_ARB_EN defined, SHALL arbitrate round-robin: when both are valid, grant the requester not granted in the most recent contested cycle; the pointer updates only on contested grants and starts favouring MEM.
REQ-027 Without REGFILE_WB_RR_ARB_EN, SHALL use fixed priority: MEM always wins when both are valid, and there SHALL be no pointer state.

Verification
REQ-028 Reset then release with no requests -> RegWrite=1, wa=0..31, wd=0 over 32 cycles; init_done=1 from cycle 32; RegWrite=0 from cycle 33.
REQ-029 Post-init alu_valid=1, alu_wa=5, alu_wd=0xDEAD -> alu_ready=1 same cycle; next cycle RegWrite=1, wa=5, wd=0xDEAD.
REQ-030 mem_valid=1, mem_wa=0, mem_wd=0x1234 -> mem_ready=1, next cycle RegWrite=0.
REQ-031 Both valid for 4 cycles (ALU wa=3, MEM wa=4) -> RR build grants MEM,ALU,MEM,ALU; fixed build grants MEM for all 4 with alu_ready=0.
REQ-032 Reset asserted at INIT cycle 10, released -> outputs immediately zero; clear sequence restarts at wa=0; init_done=0 until 32 cycles later.
REQ-033 alu_valid=1 during INIT cycle 5 -> alu_ready=0 until RUN; accepted on the first RUN cycle and written one cycle later.
